// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: FSM state encoding,
// default end-of-line byte, WAIT_BUSY guard length and counter sizing.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    localparam logic [7:0] EOL_BYTE_DEFAULT  = 8'h0A;
    localparam int         LOCK_IDLE_DEFAULT = 50000;

    // Cycles to wait for tx_busy after tx_start before giving up on the UART.
    localparam int         BUSY_GUARD        = 4;

    // idle_cnt width; at least one bit so LOCK_IDLE = 0 still elaborates.
    function automatic int cnt_width(input int lock_idle);
        return (lock_idle < 1) ? 1 : $clog2(lock_idle + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin priority picker: first set bit of req_i at or after start_i,
// wrapping modulo NREQ. Purely combinational.
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      start_i,
    output logic [NREQ-1:0] grant_o,
    output logic [1:0]      idx_o,
    output logic            any_o
);

    logic [2*NREQ-1:0] req2;
    logic [2*NREQ-1:0] rot;
    logic [1:0]        off;
    logic [2:0]        sum;
    logic              found;

    assign req2 = {req_i, req_i};

    // Rotate the request vector so start_i sits at bit 0, take the lowest set bit.
    always_comb begin
        rot   = req2 >> start_i;
        found = 1'b0;
        off   = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = 2'(k);
            end
        end
        sum = {1'b0, start_i} + {1'b0, off};
        if (sum >= 3'(NREQ)) begin
            sum = sum - 3'(NREQ);
        end
        idx_o   = sum[1:0];
        any_o   = found;
        grant_o = found ? (NREQ'(1) << sum[1:0]) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte producers. Round-robin grant
// with line locking: an owner that sent a non-EOL byte keeps the UART until
// it sends EOL_BYTE or stays idle for LOCK_IDLE cycles.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int         NREQ      = 2,
    parameter logic [7:0] EOL_BYTE  = EOL_BYTE_DEFAULT,
    parameter int         LOCK_IDLE = LOCK_IDLE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [1:0]        owner,
    output logic              locked,
    output logic [1:0]        dbg_state
);

    localparam int               CNT_W   = cnt_width(LOCK_IDLE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_IDLE);
    localparam bit               LOCK_EN = (LOCK_IDLE != 0);

    // Handshake: a byte moves from requester g to the arbiter on a rising edge
    // where req_valid[g] & req_ready[g]. req_ready is a single-cycle pulse,
    // at most one bit set, raised only in IDLE while the UART is not busy.
    // Toward the UART, tx_start is a one-cycle pulse; tx_data stays put until
    // the next accept.

    arb_state_e       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic             locked_q, locked_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [1:0]       guard_q, guard_d;
    logic             fresh_q, fresh_d;   // no grant since reset: search from 0

    logic [NREQ-1:0]  owner_mask;
    logic [NREQ-1:0]  eligible;
    logic [2:0]       owner_inc;
    logic [1:0]       start_idx;
    logic [NREQ-1:0]  pick_grant;
    logic [1:0]       pick_idx;
    logic             pick_any;
    logic [7:0]       pick_byte;
    logic             owner_valid;
    logic             accept;

    assign owner_mask  = NREQ'(1) << owner_q;
    assign owner_valid = |(req_valid & owner_mask);
    assign eligible    = locked_q ? (req_valid & owner_mask) : req_valid;
    assign owner_inc   = {1'b0, owner_q} + 3'd1;
    assign start_idx   = fresh_q ? 2'd0
                       : ((owner_inc >= 3'(NREQ)) ? 2'd0 : owner_inc[1:0]);
    assign accept      = (state_q == ST_IDLE) && !tx_busy && pick_any && !reset;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i   (eligible),
        .start_i (start_idx),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Select the winner's byte from the packed data bus.
    always_comb begin
        pick_byte = 8'h00;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_idx == 2'(k)) begin
                pick_byte = req_data[8*k +: 8];
            end
        end
    end

    // State register and all datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= 2'd0;
            locked_q   <= 1'b0;
            tx_data_q  <= 8'h00;
            idle_cnt_q <= '0;
            guard_q    <= 2'd0;
            fresh_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            locked_q   <= locked_d;
            tx_data_q  <= tx_data_d;
            idle_cnt_q <= idle_cnt_d;
            guard_q    <= guard_d;
            fresh_q    <= fresh_d;
        end
    end

    // Next-state logic, including the WAIT_BUSY guard counter.
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
                guard_d = 2'd0;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (guard_q == 2'(BUSY_GUARD - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q + 2'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture on accept; otherwise run the owner-idle timer that breaks a stale lock.
    // The timer uses locked_q, so a release is only seen by the next IDLE decision.
    always_comb begin
        owner_d    = owner_q;
        locked_d   = locked_q;
        tx_data_d  = tx_data_q;
        idle_cnt_d = idle_cnt_q;
        fresh_d    = fresh_q;
        if (accept) begin
            owner_d    = pick_idx;
            tx_data_d  = pick_byte;
            locked_d   = LOCK_EN && (pick_byte != EOL_BYTE);
            idle_cnt_d = '0;
            fresh_d    = 1'b0;
        end else if (owner_valid) begin
            idle_cnt_d = '0;
        end else if (locked_q) begin
            if (idle_cnt_q == CNT_MAX) begin
                locked_d   = 1'b0;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs: combinational ready pulse, start pulse decoded from ISSUE.
    always_comb begin
        req_ready = accept ? pick_grant : '0;
        tx_start  = (state_q == ST_ISSUE);
        tx_data   = tx_data_q;
        owner     = owner_q;
        locked    = locked_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: instance 0 has LOCK_IDLE=100, instance 1 has
// locking disabled. Each has a UART model (busy one cycle after tx_start,
// 20 cycles per byte) feeding a shared expected-byte scoreboard.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    logic        clk;
    logic        rst  [2];
    logic [1:0]  rv   [2];
    logic [15:0] rd   [2];
    logic [1:0]  rr   [2];
    logic [7:0]  txd  [2];
    logic        txs  [2];
    logic        busy [2];
    logic [1:0]  own  [2];
    logic        lk   [2];
    logic [1:0]  st   [2];

    int          n_checks = 0;
    int          n_err    = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    int          bcnt [2];
    bit          dead [2];
    bit          seen [2];

    typedef struct {
        int         req;
        logic [7:0] data;
        logic [1:0] exp_ready;
        logic [1:0] exp_owner;
        logic       exp_locked;
    } vec_t;
    vec_t vecs [6];

    uart_tx_arbiter #(.NREQ(2), .EOL_BYTE(8'h0A), .LOCK_IDLE(100)) dut_l (
        .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_data(rd[0]),
        .req_ready(rr[0]), .tx_data(txd[0]), .tx_start(txs[0]), .tx_busy(busy[0]),
        .owner(own[0]), .locked(lk[0]), .dbg_state(st[0])
    );

    uart_tx_arbiter #(.NREQ(2), .EOL_BYTE(8'h0A), .LOCK_IDLE(0)) dut_u (
        .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_data(rd[1]),
        .req_ready(rr[1]), .tx_data(txd[1]), .tx_start(txs[1]), .tx_busy(busy[1]),
        .owner(own[1]), .locked(lk[1]), .dbg_state(st[1])
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // UART model + scoreboard: start sampled mid-cycle, busy updated just after the edge.
    initial begin
        for (int k = 0; k < 2; k++) begin
            busy[k] = 1'b0; bcnt[k] = 0; dead[k] = 1'b0; seen[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                seen[k] = txs[k];
                if (seen[k]) begin
                    chk("start_while_busy", busy[k], 1'b0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_tx", 1, 0);
                    end else begin
                        chk("tx_byte", txd[k], exp_q.pop_front());
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (bcnt[k] > 0) bcnt[k]--;
                if (seen[k] && !dead[k]) bcnt[k] = 20;
                busy[k] = (bcnt[k] != 0);
            end
        end
    end

    task automatic wait_quiet(input int s);
        int n;
        n = 0;
        while (!(st[s] == ST_IDLE && busy[s] == 1'b0 && exp_q.size() == 0) && n < 400) begin
            @(posedge clk); #2;
            n++;
        end
        chk("quiet_timeout", (n < 400), 1);
    endtask

    // Reset with both valids high: ready must stay low and outputs at reset values.
    task automatic do_reset(input int s);
        @(negedge clk);
        rst[s] = 1'b1; rv[s] = 2'b11; rd[s] = 16'hA5A5;
        @(posedge clk); #2;
        chk("rst_ready",    rr[s],  2'b00);
        chk("rst_tx_start", txs[s], 1'b0);
        chk("rst_tx_data",  txd[s], 8'h00);
        chk("rst_owner",    own[s], 2'd0);
        chk("rst_locked",   lk[s],  1'b0);
        chk("rst_state",    st[s],  ST_IDLE);
        @(negedge clk);
        rst[s] = 1'b0; rv[s] = 2'b00; rd[s] = 16'h0000;
    endtask

    task automatic send_one(input int s, input vec_t v);
        int n;
        exp_q.push_back(v.data);
        @(negedge clk);
        rv[s] = 2'b01 << v.req;
        rd[s] = 16'(v.data) << (8 * v.req);
        #1;
        n = 0;
        while (rr[s] == 2'b00 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("v_ready",      rr[s],  v.exp_ready);
        chk("v_no_start",   txs[s], 1'b0);
        @(posedge clk); #2;
        rv[s] = 2'b00;
        chk("v_tx_start",   txs[s], 1'b1);
        chk("v_tx_data",    txd[s], v.data);
        chk("v_owner",      own[s], v.exp_owner);
        chk("v_locked",     lk[s],  v.exp_locked);
        chk("v_ready_drop", rr[s],  2'b00);
        @(posedge clk); #2;
        chk("v_start_pulse", txs[s], 1'b0);
        wait_quiet(s);
    endtask

    // Stream q0/q1 as two always-ready producers until both queues drain.
    task automatic run_queues(input int s, input bit lock_en, input int budget);
        int         cyc;
        logic [1:0] r;
        logic [7:0] b;
        bit         acc;
        cyc = 0;
        while ((q0.size() != 0 || q1.size() != 0) && cyc < budget) begin
            @(negedge clk);
            rv[s] = {q1.size() != 0, q0.size() != 0};
            rd[s] = {(q1.size() != 0) ? q1[0] : 8'h00, (q0.size() != 0) ? q0[0] : 8'h00};
            #1;
            r = rr[s]; acc = 1'b0; b = 8'h00;
            if (r != 2'b00) begin
                chk("rq_onehot", 32'($onehot(r)), 1);
                acc = 1'b1;
                if (r[0]) b = q0.pop_front();
                else      b = q1.pop_front();
            end
            @(posedge clk); #2;
            if (acc) begin
                chk("rq_tx_start", txs[s], 1'b1);
                chk("rq_locked",   lk[s],  lock_en && (b != 8'h0A));
            end
            cyc++;
        end
        rv[s] = 2'b00;
        chk("rq_drained", q0.size() + q1.size(), 0);
        wait_quiet(s);
    endtask

    initial begin
        bit early;
        int n;
        vecs[0] = '{0, 8'h41, 2'b01, 2'd0, 1'b1};
        vecs[1] = '{0, 8'h0A, 2'b01, 2'd0, 1'b0};
        vecs[2] = '{1, 8'h55, 2'b10, 2'd1, 1'b1};
        vecs[3] = '{1, 8'h0A, 2'b10, 2'd1, 1'b0};
        vecs[4] = '{0, 8'h5A, 2'b01, 2'd0, 1'b1};
        vecs[5] = '{0, 8'h0A, 2'b01, 2'd0, 1'b0};

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; rv[k] = 2'b00; rd[k] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        do_reset(0);
        do_reset(1);

        // Single bytes through the table, lock set by text, cleared by EOL.
        for (int i = 0; i < 6; i++) begin
            send_one(0, vecs[i]);
        end

        // Line lock: req0 "AB\n" finishes before req1 "xy\n" starts.
        do_reset(0);
        q0 = '{8'h41, 8'h42, 8'h0A};
        q1 = '{8'h78, 8'h79, 8'h0A};
        exp_q = '{8'h41, 8'h42, 8'h0A, 8'h78, 8'h79, 8'h0A};
        run_queues(0, 1'b1, 600);

        // Locking disabled: strict alternation.
        do_reset(1);
        q0 = '{8'h30, 8'h31};
        q1 = '{8'h40, 8'h41};
        exp_q = '{8'h30, 8'h40, 8'h31, 8'h41};
        run_queues(1, 1'b0, 400);

        // Idle release: req1 waits exactly until the 100-cycle owner-idle timeout.
        do_reset(0);
        exp_q = '{8'h41, 8'h55};
        @(negedge clk);
        rv[0] = 2'b11; rd[0] = {8'h55, 8'h41};
        #1;
        chk("idle_first_ready", rr[0], 2'b01);
        @(posedge clk); #2;
        rv[0] = 2'b10;
        chk("idle_locked_set", lk[0], 1'b1);
        early = 1'b0;
        for (int k = 1; k <= 101; k++) begin
            @(posedge clk); #2;
            if (k <= 100 && (rr[0] != 2'b00 || lk[0] != 1'b1)) early = 1'b1;
            if (k == 100) chk("idle_locked_100", lk[0], 1'b1);
            if (k == 101) begin
                chk("idle_locked_101", lk[0], 1'b0);
                chk("idle_ready_101",  rr[0], 2'b10);
            end
        end
        chk("idle_no_early_release", early, 1'b0);
        @(posedge clk); #2;
        rv[0] = 2'b00;
        chk("idle_owner1", own[0], 2'd1);
        chk("idle_start1", txs[0], 1'b1);
        wait_quiet(0);

        // Busy guard: UART never answers, FSM must fall back to IDLE.
        dead[0] = 1'b1;
        do_reset(0);
        exp_q.push_back(8'h0A);
        @(negedge clk);
        rv[0] = 2'b01; rd[0] = 16'h000A;
        #1;
        chk("guard_ready", rr[0], 2'b01);
        @(posedge clk); #2;
        rv[0] = 2'b00;
        chk("guard_issue", st[0], ST_ISSUE);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #2;
            chk("guard_state", st[0], (k <= 4) ? ST_WAIT_BUSY : ST_IDLE);
        end
        send_one(0, '{0, 8'h33, 2'b01, 2'd0, 1'b1});
        dead[0] = 1'b0;

        // Reset in WAIT_DONE while the UART keeps running.
        do_reset(0);
        exp_q.push_back(8'h41);
        @(negedge clk);
        rv[0] = 2'b01; rd[0] = 16'h0041;
        #1;
        chk("mid_ready", rr[0], 2'b01);
        @(posedge clk); #2;
        rv[0] = 2'b00;
        n = 0;
        while (st[0] != ST_WAIT_DONE && n < 10) begin
            @(posedge clk); #2;
            n++;
        end
        chk("mid_reached_wait_done", st[0], ST_WAIT_DONE);
        exp_q.push_back(8'h55);
        @(negedge clk);
        rst[0] = 1'b1; rv[0] = 2'b10; rd[0] = 16'h5500;
        @(posedge clk); #2;
        chk("mid_busy_still", busy[0], 1'b1);
        chk("mid_ready0",  rr[0],  2'b00);
        chk("mid_start0",  txs[0], 1'b0);
        chk("mid_data0",   txd[0], 8'h00);
        chk("mid_owner0",  own[0], 2'd0);
        chk("mid_locked0", lk[0],  1'b0);
        chk("mid_state0",  st[0],  ST_IDLE);
        @(negedge clk);
        rst[0] = 1'b0;
        #1;
        n = 0;
        while (rr[0] == 2'b00 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        chk("mid_grant_after_busy", rr[0], 2'b10);
        chk("mid_grant_not_busy", busy[0], 1'b0);
        @(posedge clk); #2;
        rv[0] = 2'b00;
        wait_quiet(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
